// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } stall_state_e;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_MEM_TIMEOUT  = 15;
  localparam int DEF_FLUSH_CYCLES = 2;

  // Load-use hazard: a load in ID/EX writes a non-zero register read in IF/ID.
  // Bit 5 of the destination is masked off so only the 5-bit register index matters.
  function automatic logic load_use_hit(input logic       memrd,
                                        input logic [5:0] wr_reg,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    logic [5:0] dst;
    dst = wr_reg & 6'h1F;
    return memrd && (dst != 6'd0) &&
           ((dst == {1'b0, rs1}) || (dst == {1'b0, rs2}));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory waits with timeout,
// and branch flushes, with a saturating count of non-RUN cycles.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_memrd,
  input  logic [5:0]       de_wr_reg,
  input  logic [4:0]       f_rs1,
  input  logic [4:0]       f_rs2,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W  = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT  + 1) : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  stall_state_e        state_q, state_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic                pend_q,  pend_d;
  logic                tmo_q,   tmo_d;

  logic mem_stall;
  logic lu_hit;
  logic flush_due;

  assign mem_stall = mem_req & ~mem_ack;
  assign lu_hit    = load_use_hit(de_memrd, de_wr_reg, f_rs1, f_rs2);
  // A branch seen on the exit cycle of a memory wait still forces the flush.
  assign flush_due = pend_q | ex_branch_taken;

  // Next-state, wait/flush counters, pending-flush and timeout flag.
  // A branch that coincides with a new memory stall is remembered in pend
  // so it is not lost while the pipe is held.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    flush_d = flush_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
          pend_d  = ex_branch_taken;
        end else if (ex_branch_taken) begin
          state_d = ST_FLUSH;
          flush_d = '0;
          pend_d  = 1'b0;
        end else if (lu_hit) begin
          state_d = ST_LU_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        pend_d = flush_due;
        if (mem_ack || (wait_q == WAIT_LAST)) begin
          if (!mem_ack) begin
            tmo_d = 1'b1;
          end
          if (flush_due) begin
            state_d = ST_FLUSH;
            flush_d = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
          pend_d  = 1'b1;
        end else if (ex_branch_taken) begin
          flush_d = '0;
        end else if (flush_q == FLUSH_LAST) begin
          state_d = ST_RUN;
        end else begin
          flush_d = flush_q + FLUSH_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (cnt_clr) begin
      tmo_d = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      flush_q <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    pc_wr        = 1'b0;
    if_id_wr     = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_hold    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pc_wr    = 1'b1;
        if_id_wr = 1'b1;
      end
      ST_LU_STALL: begin
        id_ex_bubble = 1'b1;
      end
      ST_MEM_WAIT: begin
        pipe_hold = 1'b1;
      end
      ST_FLUSH: begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: begin
        pc_wr    = 1'b1;
        if_id_wr = 1'b1;
      end
    endcase
  end

  sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (state_q != ST_RUN),
    .cnt  (stall_cnt)
  );

  assign mem_timeout = tmo_q;

endmodule
